// File: rtl/mar_arbiter.sv
// mar_arbiter: grants the shared MAR to fetch (1) or operand (2) requester,
// pulses its load enable, waits a fixed memory latency and returns a done pulse.
module mar_arbiter #(
  parameter int MEM_LAT   = 2,
  parameter bit PRIO_MODE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req1,
  input  logic req2,
  output logic re1,
  output logic re2,
  output logic gnt1,
  output logic gnt2,
  output logic mem_en,
  output logic done1,
  output logic done2,
  output logic busy
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;
  localparam logic [3:0] CNT_INIT = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);
  generate
    if (MEM_LAT < 0 || MEM_LAT > 15) begin : g_bad_lat
      $error("mar_arbiter: MEM_LAT must be in 0..15");
    end
  endgenerate
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       own_q, own_d;
  logic       pick;
  // last_q/own_q: 0 = requester 1, 1 = requester 2
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      own_q   <= own_d;
    end
  end
  assign pick = (req1 & req2) ? (PRIO_MODE ? 1'b0 : ~last_q) : req2;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    own_d   = own_q;
    case (state_q)
      S_IDLE: if (req1 | req2) begin
        state_d = S_LOAD;
        own_d   = pick;
        last_d  = pick;
      end
      S_LOAD: begin
        state_d = (MEM_LAT == 0) ? S_DONE : S_WAIT;
        cnt_d   = CNT_INIT;
      end
      S_WAIT: begin
        cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        state_d = (cnt_q == 4'd0) ? S_DONE : S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    busy   = state_q != S_IDLE;
    gnt1   = busy & ~own_q;
    gnt2   = busy & own_q;
    re1    = (state_q == S_LOAD) & ~own_q;
    re2    = (state_q == S_LOAD) & own_q;
    mem_en = state_q == S_WAIT;
    done1  = (state_q == S_DONE) & ~own_q;
    done2  = (state_q == S_DONE) & own_q;
  end
endmodule

// File: tb/tb_mar_arbiter.sv
// tb_mar_arbiter: directed scoreboard bench over three parameterisations of mar_arbiter.
module tb_mar_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] r1v = '0, r2v = '0;
  logic [7:0] ov [3];
  int vectors = 0, miscompares = 0;
  // output vector bit order: {re1,re2,gnt1,gnt2,mem_en,done1,done2,busy}
  localparam logic [7:0] ID = 8'b0000_0000;
  localparam logic [7:0] L1 = 8'b1010_0001;
  localparam logic [7:0] L2 = 8'b0101_0001;
  localparam logic [7:0] W1 = 8'b0010_1001;
  localparam logic [7:0] W2 = 8'b0001_1001;
  localparam logic [7:0] D1 = 8'b0010_0101;
  localparam logic [7:0] D2 = 8'b0001_0011;
  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } sb_t;
  sb_t sb[$];
  always #5 clk = ~clk;
  mar_arbiter #(.MEM_LAT(2), .PRIO_MODE(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req1(r1v[0]), .req2(r2v[0]),
    .re1(ov[0][7]), .re2(ov[0][6]), .gnt1(ov[0][5]), .gnt2(ov[0][4]),
    .mem_en(ov[0][3]), .done1(ov[0][2]), .done2(ov[0][1]), .busy(ov[0][0]));
  mar_arbiter #(.MEM_LAT(2), .PRIO_MODE(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req1(r1v[1]), .req2(r2v[1]),
    .re1(ov[1][7]), .re2(ov[1][6]), .gnt1(ov[1][5]), .gnt2(ov[1][4]),
    .mem_en(ov[1][3]), .done1(ov[1][2]), .done2(ov[1][1]), .busy(ov[1][0]));
  mar_arbiter #(.MEM_LAT(0), .PRIO_MODE(1'b0)) dut_z (
    .clk(clk), .rst_n(rst_n), .req1(r1v[2]), .req2(r2v[2]),
    .re1(ov[2][7]), .re2(ov[2][6]), .gnt1(ov[2][5]), .gnt2(ov[2][4]),
    .mem_en(ov[2][3]), .done1(ov[2][2]), .done2(ov[2][1]), .busy(ov[2][0]));
  task automatic step(input int sel, input logic rn, input logic a, input logic b,
                      input logic [7:0] exp, input string tag);
    sb_t        e;
    logic [7:0] o;
    logic       inv_ok;
    rst_n = rn;
    r1v = '0;
    r2v = '0;
    r1v[sel] = a;
    r2v[sel] = b;
    sb.push_back('{tag, sel, exp});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    o = ov[e.sel];
    vectors++;
    assert (o === e.exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", e.tag, o, e.exp);
    end
    inv_ok = !(o[7] & o[6]) && !(o[5] & o[4]) && !(o[2] & o[1]) &&
             (!o[7] || o[5]) && (!o[6] || o[4]) && (!o[2] || o[5]) && (!o[1] || o[4]);
    vectors++;
    assert (inv_ok === 1'b1) else begin
      miscompares++;
      $error("FAIL %s_invariant: observed %b expected exclusive grant/pulse vector", e.tag, o);
    end
  endtask
  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b1, 1'b1, ID, "reset_hold");
    step(0, 1'b1, 1'b1, 1'b1, L1, "rr_load1");
    step(0, 1'b1, 1'b1, 1'b1, W1, "rr_wait1a");
    step(0, 1'b1, 1'b1, 1'b1, W1, "rr_wait1b");
    step(0, 1'b1, 1'b1, 1'b1, D1, "rr_done1");
    step(0, 1'b1, 1'b1, 1'b1, ID, "rr_idle1");
    step(0, 1'b1, 1'b1, 1'b1, L2, "rr_load2");
    step(0, 1'b1, 1'b1, 1'b1, W2, "rr_wait2a");
    step(0, 1'b1, 1'b1, 1'b1, W2, "rr_wait2b");
    step(0, 1'b1, 1'b1, 1'b1, D2, "rr_done2");
    step(0, 1'b1, 1'b1, 1'b1, ID, "rr_idle2");
    step(0, 1'b1, 1'b1, 1'b1, L1, "rr_load3");
    step(0, 1'b1, 1'b1, 1'b1, W1, "rr_wait3a");
    step(0, 1'b1, 1'b1, 1'b1, W1, "rr_wait3b");
    step(0, 1'b1, 1'b1, 1'b1, D1, "rr_done3");
    step(0, 1'b1, 1'b1, 1'b1, ID, "rr_idle3");
    step(0, 1'b1, 1'b1, 1'b1, L2, "rr_load4");
    step(0, 1'b1, 1'b1, 1'b1, W2, "rr_wait4a");
    step(0, 1'b1, 1'b1, 1'b1, W2, "rr_wait4b");
    step(0, 1'b1, 1'b1, 1'b1, D2, "rr_done4");
    step(0, 1'b1, 1'b0, 1'b0, ID, "rr_idle4");
    step(0, 1'b1, 1'b0, 1'b0, ID, "idle_noreq");
    step(0, 1'b1, 1'b1, 1'b0, L1, "single_load");
    step(0, 1'b1, 1'b1, 1'b0, W1, "single_wait_a");
    step(0, 1'b1, 1'b1, 1'b0, W1, "single_wait_b");
    step(0, 1'b1, 1'b1, 1'b0, D1, "single_done");
    step(0, 1'b1, 1'b0, 1'b0, ID, "single_idle");
    step(1, 1'b1, 1'b1, 1'b1, L1, "fp_load1");
    step(1, 1'b1, 1'b1, 1'b1, W1, "fp_wait1a");
    step(1, 1'b1, 1'b1, 1'b1, W1, "fp_wait1b");
    step(1, 1'b1, 1'b1, 1'b1, D1, "fp_done1");
    step(1, 1'b1, 1'b1, 1'b1, ID, "fp_idle1");
    step(1, 1'b1, 1'b1, 1'b1, L1, "fp_load1_again");
    step(1, 1'b1, 1'b1, 1'b1, W1, "fp_wait2a");
    step(1, 1'b1, 1'b1, 1'b1, W1, "fp_wait2b");
    step(1, 1'b1, 1'b1, 1'b1, D1, "fp_done2");
    step(1, 1'b1, 1'b0, 1'b1, ID, "fp_idle2");
    step(1, 1'b1, 1'b0, 1'b1, L2, "fp_load_req2");
    step(1, 1'b1, 1'b0, 1'b1, W2, "fp_wait3a");
    step(1, 1'b1, 1'b0, 1'b1, W2, "fp_wait3b");
    step(1, 1'b1, 1'b0, 1'b1, D2, "fp_done_req2");
    step(1, 1'b1, 1'b0, 1'b0, ID, "fp_idle3");
    step(0, 1'b1, 1'b0, 1'b1, L2, "mid_load2");
    step(0, 1'b1, 1'b0, 1'b1, W2, "mid_wait2");
    step(0, 1'b0, 1'b0, 1'b1, ID, "mid_reset");
    step(0, 1'b0, 1'b0, 1'b1, ID, "mid_reset_nodone");
    step(0, 1'b1, 1'b0, 1'b1, L2, "mid_fresh_load2");
    step(0, 1'b1, 1'b0, 1'b1, W2, "mid_fresh_wait_a");
    step(0, 1'b1, 1'b0, 1'b1, W2, "mid_fresh_wait_b");
    step(0, 1'b1, 1'b0, 1'b1, D2, "mid_fresh_done2");
    step(0, 1'b1, 1'b0, 1'b0, ID, "mid_fresh_idle");
    step(2, 1'b1, 1'b1, 1'b0, L1, "lat0_load1");
    step(2, 1'b1, 1'b0, 1'b0, D1, "lat0_done1");
    step(2, 1'b1, 1'b0, 1'b0, ID, "lat0_idle");
    step(2, 1'b1, 1'b0, 1'b1, L2, "lat0_load2");
    step(2, 1'b1, 1'b0, 1'b1, D2, "lat0_done2");
    step(2, 1'b1, 1'b0, 1'b0, ID, "lat0_idle2");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mar_arbiter.md
Name: mar_arbiter

Overview:
Sequencer and arbiter that shares the 15-bit memory address register between two requesters: requester 1 (instruction fetch) and requester 2 (data/operand access). It grants one requester at a time and pulses the matching MAR load enable (re1 or re2) for exactly one cycle. It then holds the grant while memory completes a fixed-latency access, and returns a one-cycle done pulse. It sits between the fetch/execute control logic and the MAR, and drives the MAR's re1/re2 inputs directly.

Parameters:
MEM_LAT, 2, memory access cycles after MAR load; legal range 0..15.
PRIO_MODE, 0, 0 = round-robin between requesters; 1 = fixed priority, requester 1 always wins.

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  reset, synchronous, active-low
req1  input  1  requester 1 access request, level
req2  input  1  requester 2 access request, level
re1  output  1  MAR load from in1, one-cycle pulse
re2  output  1  MAR load from in2, one-cycle pulse
gnt1  output  1  requester 1 owns MAR/memory
gnt2  output  1  requester 2 owns MAR/memory
mem_en  output  1  memory access enable
done1  output  1  requester 1 access complete, one-cycle pulse
done2  output  1  requester 2 access complete, one-cycle pulse
busy  output  1  arbiter not idle

Behaviour:
- Timing: one clock; reset is synchronous and active-low. All outputs are registered or decoded from registered state, with no combinational path from req to outputs.
- Reset (rst_n=0 at a posedge):
  - state=IDLE, wait counter=0, last-served flag=2 (so requester 1 wins the first tie).
  - All outputs 0.
  - Reset applies mid-access: the access is abandoned, with no done pulse and no re pulse.
- State machine, 2-bit state:
  - IDLE: busy=0 and all outputs 0. If req1|req2 is high, pick a winner and go to LOAD; otherwise stay.
  - LOAD (1 cycle): gntX=1, reX=1, busy=1. Go to WAIT with counter=MEM_LAT-1, or to DONE if MEM_LAT=0.
  - WAIT (MEM_LAT cycles): gntX=1, mem_en=1, busy=1. Counter decrements each cycle; go to DONE when counter=0.
  - DONE (1 cycle): gntX=1, doneX=1, busy=1. Go to IDLE.
- Arbitration (evaluated only in IDLE):
  - Only one request high: that requester wins.
  - Both high, PRIO_MODE=0: the requester not served last wins. PRIO_MODE=1: requester 1 wins.
  - The last-served flag updates on the IDLE->LOAD transition.
- Latency and throughput:
  - req high in IDLE cycle N: re pulse in cycle N+1; done pulse in cycle N+2+MEM_LAT; IDLE again in cycle N+3+MEM_LAT.
  - One access takes MEM_LAT+3 cycles including the arbitration cycle.
- Handshake rules:
  - A requester holds req until it samples done.
  - req changes during LOAD/WAIT/DONE are ignored; a granted access always completes.
  - req still high in IDLE after done counts as a new request.
- Invariants:
  - re1&re2, gnt1&gnt2 and done1&done2 are never 1 together.
  - reX and doneX are asserted only while gntX=1.
  - re pulses occur exactly once per grant.
- Counter: 4 bits, no wrap. MEM_LAT>15 is illegal; flag it with a simulation-only check.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with req1=req2=1 -> all outputs 0 throughout. Release at cycle 3 -> re1=1 at cycle 4 (requester 1 wins first).
2. Single access, MEM_LAT=2: req1=1 in IDLE at cycle 0 -> re1 at cycle 1, mem_en at cycles 2-3, done1 at cycle 4, busy=0 at cycle 5. re2/gnt2/done2 stay 0.
3. Round-robin, PRIO_MODE=0, MEM_LAT=2, req1=req2=1 continuously -> grants alternate 1,2,1,2 with re pulses every 5 cycles. re1 and re2 are never both high.
4. Fixed priority, PRIO_MODE=1, both held -> every grant goes to requester 1. Drop req1 at its done edge -> next grant goes to requester 2.
5. Reset mid-access: req2 granted, rst_n=0 during WAIT -> next cycle all outputs 0 and no done2 pulse. Release with only req2=1 -> a fresh re2 pulse one cycle after IDLE.
6. MEM_LAT=0 with req1 dropped during LOAD -> mem_en never asserted, and done1 is asserted in the cycle after re1 (access completes despite the drop).
